// File: rtl/b16_sram_pkg.sv
// Shared types and constants for the async-SRAM responder.
// No logic, no latency; nothing here applies backpressure.
package b16_sram_pkg;

    localparam int ADDR_W_DEF = 15;

    localparam logic [1:0] LANE_HI   = 2'b10;
    localparam logic [1:0] LANE_LO   = 2'b01;
    localparam logic [1:0] LANE_BOTH = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_HOLD = 3'd2,
        ST_WR_WAIT = 3'd3,
        ST_WR_REQ  = 3'd4
    } sram_state_t;

    // Active-low pin lanes to the {upper, lower} byte-write mask.
    function automatic logic [1:0] lanes_of(input logic ub_n, input logic lb_n);
        return {~ub_n, ~lb_n};
    endfunction

endpackage

// File: rtl/sram_target_if.sv
// External async-SRAM pins plus the internal memory request port.
// No logic, no latency; mem_ready is the only backpressure on the request side.
interface sram_target_if #(parameter int ADDR_W = b16_sram_pkg::ADDR_W_DEF);
    logic [ADDR_W-1:0] ext_addr;
    logic [15:0]       ext_dq_i;
    logic [15:0]       ext_dq_o;
    logic              ext_dq_oe;
    logic              ext_ce_n;
    logic              ext_oe_n;
    logic              ext_we_n;
    logic              ext_ub_n;
    logic              ext_lb_n;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_r;
    logic [1:0]        mem_w;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_ready;

    modport slave (
        input  ext_addr, ext_dq_i, ext_ce_n, ext_oe_n, ext_we_n, ext_ub_n, ext_lb_n,
        input  mem_rdata, mem_ready,
        output ext_dq_o, ext_dq_oe, mem_addr, mem_r, mem_w, mem_wdata
    );

    modport master (
        output ext_addr, ext_dq_i, ext_ce_n, ext_oe_n, ext_we_n, ext_ub_n, ext_lb_n,
        output mem_rdata, mem_ready,
        input  ext_dq_o, ext_dq_oe, mem_addr, mem_r, mem_w, mem_wdata
    );
endinterface

// File: rtl/sync_bits.sv
// Multi-stage flop synchroniser for a bundle of asynchronous inputs.
// Latency STAGES clk; no backpressure.
module sync_bits #(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < STAGES; i++) stage[i] <= RESET_VAL;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/sram_target.sv
// Async-SRAM responder: one internal request per external access, strobes synchronised.
// Read: ext_dq_oe SYNC_STAGES+2 clk after CE/OE fall; write: mem_w SYNC_STAGES+1 clk after WE/CE rise; held until mem_ready.
module sram_target
    import b16_sram_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          nreset,
    sram_target_if.slave  bus,
    output logic          busy,
    output logic          err
);

    localparam int DW = ADDR_W + 16;

    logic [4:0]        strb_s;
    logic [DW-1:0]     ad_s;
    logic              ce_s, oe_s, we_s, ub_s, lb_s;
    logic [ADDR_W-1:0] addr_s;
    logic [15:0]       dq_s;

    // Address/data share the strobe depth so they line up with the strobes.
    sync_bits #(.WIDTH(5), .STAGES(SYNC_STAGES), .RESET_VAL(5'b11111)) u_sync_strb (
        .clk    (clk),
        .nreset (nreset),
        .d      ({bus.ext_ce_n, bus.ext_oe_n, bus.ext_we_n, bus.ext_ub_n, bus.ext_lb_n}),
        .q      (strb_s)
    );

    sync_bits #(.WIDTH(DW), .STAGES(SYNC_STAGES), .RESET_VAL('0)) u_sync_data (
        .clk    (clk),
        .nreset (nreset),
        .d      ({bus.ext_addr, bus.ext_dq_i}),
        .q      (ad_s)
    );

    assign {ce_s, oe_s, we_s, ub_s, lb_s} = strb_s;
    assign {addr_s, dq_s} = ad_s;

    sram_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              mem_r_q, mem_r_d;
    logic [1:0]        mem_w_q, mem_w_d;
    logic [15:0]       dq_o_q, dq_o_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [15:0]       hold_data_q, hold_data_d;
    logic [1:0]        hold_lanes_q, hold_lanes_d;
    logic              ce_prev_q, we_prev_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_r_q      <= 1'b0;
            mem_w_q      <= 2'b00;
            dq_o_q       <= 16'h0000;
            rd_valid_q   <= 1'b0;
            err_q        <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            hold_lanes_q <= 2'b00;
            ce_prev_q    <= 1'b1;
            we_prev_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_r_q      <= mem_r_d;
            mem_w_q      <= mem_w_d;
            dq_o_q       <= dq_o_d;
            rd_valid_q   <= rd_valid_d;
            err_q        <= err_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            hold_lanes_q <= hold_lanes_d;
            ce_prev_q    <= ce_s;
            we_prev_q    <= we_s;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_r_d      = mem_r_q;
        mem_w_d      = mem_w_q;
        dq_o_d       = dq_o_q;
        rd_valid_d   = rd_valid_q;
        err_d        = err_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        hold_lanes_d = hold_lanes_q;

        // A new access starting under a pending request cannot be served.
        if ((state_q == ST_RD_REQ || state_q == ST_WR_REQ) &&
            ((ce_prev_q && !ce_s) || (we_prev_q && !we_s)))
            err_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (!ce_s && !we_s) begin
                    state_d      = ST_WR_WAIT;
                    hold_addr_d  = addr_s;
                    hold_data_d  = dq_s;
                    hold_lanes_d = lanes_of(ub_s, lb_s);
                end else if (!ce_s && !oe_s) begin
                    state_d = ST_RD_REQ;
                    addr_d  = addr_s;
                    mem_r_d = 1'b1;
                end
            end
            ST_RD_REQ: begin
                if (bus.mem_ready) begin
                    state_d    = ST_RD_HOLD;
                    dq_o_d     = bus.mem_rdata;
                    rd_valid_d = 1'b1;
                    mem_r_d    = 1'b0;
                end
            end
            ST_RD_HOLD: begin
                if (ce_s || oe_s) begin
                    state_d    = ST_IDLE;
                    rd_valid_d = 1'b0;
                end else if (!we_s) begin
                    state_d      = ST_WR_WAIT;
                    rd_valid_d   = 1'b0;
                    hold_addr_d  = addr_s;
                    hold_data_d  = dq_s;
                    hold_lanes_d = lanes_of(ub_s, lb_s);
                end else if (addr_s != addr_q) begin
                    state_d    = ST_RD_REQ;
                    rd_valid_d = 1'b0;
                    addr_d     = addr_s;
                    mem_r_d    = 1'b1;
                end
            end
            ST_WR_WAIT: begin
                if (!ce_s && !we_s) begin
                    hold_addr_d  = addr_s;
                    hold_data_d  = dq_s;
                    hold_lanes_d = lanes_of(ub_s, lb_s);
                end else if (hold_lanes_q == 2'b00) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WR_REQ;
                    addr_d  = hold_addr_q;
                    wdata_d = hold_data_q;
                    mem_w_d = hold_lanes_q;
                end
            end
            ST_WR_REQ: begin
                if (bus.mem_ready) begin
                    state_d = ST_IDLE;
                    mem_w_d = 2'b00;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_r     = mem_r_q;
    assign bus.mem_w     = mem_w_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.ext_dq_o  = dq_o_q;
    // Raw pins so the pad releases the instant the master lets go.
    assign bus.ext_dq_oe = rd_valid_q & ~bus.ext_ce_n & ~bus.ext_oe_n & bus.ext_we_n;
    assign busy          = (state_q != ST_IDLE);
    assign err           = err_q;

endmodule

// File: tb/tb_sram_target.sv
// Bench for sram_target: pin-level master, randomised memory responder, scoreboard.
module tb_sram_target;
    import b16_sram_pkg::*;

    localparam int AW = 15;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic busy, err;
    always #10 clk = ~clk;

    sram_target_if #(.ADDR_W(AW)) bus();

    sram_target #(.ADDR_W(AW), .SYNC_STAGES(SS)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus),
        .busy   (busy),
        .err    (err)
    );

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [1:0]    lanes;
        logic [15:0]   data;
    } req_t;

    req_t        exp_q[$];
    logic [15:0] rd_exp_q[$];
    logic [15:0] ref_mem  [0:(1<<AW)-1];
    logic [15:0] resp_mem [0:(1<<AW)-1];

    int n_chk = 0;
    int n_fail = 0;
    int fixed_wait = 0;
    bit hold_ready = 1'b0;
    int wait_cnt = 0;
    bit in_req = 1'b0;
    bit oe_prev = 1'b0;

    function automatic logic [15:0] merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                          input logic [1:0] lanes);
        merge = old_v;
        if (lanes[1]) merge[15:8] = new_v[15:8];
        if (lanes[0]) merge[7:0]  = new_v[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory responder and request monitor.
    always @(negedge clk) begin
        if (!nreset) begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = 16'h0000;
            in_req = 1'b0;
        end else if (bus.mem_ready) begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = 16'($urandom);
            in_req = 1'b0;
        end else if (bus.mem_r || bus.mem_w != 2'b00) begin
            if (!in_req) begin
                in_req = 1'b1;
                wait_cnt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
                chk("req_exclusive", 32'(bus.mem_r && bus.mem_w != 2'b00), 0);
            end
            if (!hold_ready) begin
                if (wait_cnt == 0) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = resp_mem[bus.mem_addr];
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_req: actual addr=%0h r=%0b w=%0b required none",
                                 bus.mem_addr, bus.mem_r, bus.mem_w);
                    end else begin
                        req_t e;
                        e = exp_q.pop_front();
                        chk("req_kind", 32'(bus.mem_w != 2'b00), 32'(e.is_wr));
                        chk("req_addr", 32'(bus.mem_addr), 32'(e.addr));
                        if (e.is_wr) begin
                            chk("req_lanes", 32'(bus.mem_w), 32'(e.lanes));
                            chk("req_wdata", 32'(bus.mem_wdata), 32'(e.data));
                            resp_mem[bus.mem_addr] = merge(resp_mem[bus.mem_addr], bus.mem_wdata, bus.mem_w);
                        end
                    end
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Read-data monitor: each rise of the pad enable presents one read word.
    always @(negedge clk) begin
        if (!nreset) begin
            oe_prev = 1'b0;
        end else begin
            if (bus.ext_dq_oe && !oe_prev) begin
                if (rd_exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_rd: actual dq=%0h required none", bus.ext_dq_o);
                end else begin
                    chk("rd_data", 32'(bus.ext_dq_o), 32'(rd_exp_q.pop_front()));
                end
            end
            oe_prev = bus.ext_dq_oe;
        end
    end

    task automatic pins_idle();
        bus.ext_ce_n = 1'b1;
        bus.ext_oe_n = 1'b1;
        bus.ext_we_n = 1'b1;
        bus.ext_ub_n = 1'b1;
        bus.ext_lb_n = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 60 && busy; k++) @(negedge clk);
        chk(name, 32'(busy), 0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [15:0] d, input logic ub_n,
                            input logic lb_n, input int hold, input bit chk_t);
        logic [1:0] lanes;
        req_t e;
        int first, cnt;
        @(negedge clk);
        bus.ext_addr = a;
        bus.ext_dq_i = d;
        bus.ext_ub_n = ub_n;
        bus.ext_lb_n = lb_n;
        bus.ext_ce_n = 1'b0;
        bus.ext_we_n = 1'b0;
        repeat (hold) @(negedge clk);
        pins_idle();
        lanes = {~ub_n, ~lb_n};
        if (lanes != 2'b00) begin
            e.is_wr = 1'b1; e.addr = a; e.lanes = lanes; e.data = d;
            exp_q.push_back(e);
            ref_mem[a] = merge(ref_mem[a], d, lanes);
        end
        first = 0;
        cnt = 0;
        for (int k = 1; k <= SS + 4; k++) begin
            @(negedge clk);
            if (bus.mem_w != 2'b00) begin
                cnt++;
                if (first == 0) first = k;
            end
        end
        if (chk_t) begin
            chk("wr_pulse_count", 32'(cnt), 32'(lanes != 2'b00));
            if (lanes != 2'b00) chk("wr_latency", 32'(first), 32'(SS + 1));
        end
        wait_idle("wr_idle");
    endtask

    task automatic do_read(input logic [AW-1:0] a, input bit chg, input logic [AW-1:0] a2,
                           input bit chk_t);
        req_t e;
        int k, rcnt;
        @(negedge clk);
        bus.ext_addr = a;
        bus.ext_we_n = 1'b1;
        bus.ext_ce_n = 1'b0;
        bus.ext_oe_n = 1'b0;
        e.is_wr = 1'b0; e.addr = a; e.lanes = 2'b00; e.data = 16'h0;
        exp_q.push_back(e);
        rd_exp_q.push_back(ref_mem[a]);
        rcnt = 0;
        for (k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.mem_r) rcnt++;
            if (bus.ext_dq_oe) break;
        end
        chk("rd_oe_rise", 32'(bus.ext_dq_oe), 1);
        if (chk_t) begin
            chk("rd_latency", 32'(k), 32'(SS + 5));
            chk("rd_mem_r_cycles", 32'(rcnt), 4);
        end
        if (chg) begin
            bus.ext_addr = a2;
            e.addr = a2;
            exp_q.push_back(e);
            rd_exp_q.push_back(ref_mem[a2]);
            for (k = 0; k < 60 && bus.ext_dq_oe; k++) @(negedge clk);
            chk("rd_chg_drop", 32'(bus.ext_dq_oe), 0);
            for (k = 0; k < 60 && !bus.ext_dq_oe; k++) @(negedge clk);
            chk("rd_chg_back", 32'(bus.ext_dq_oe), 1);
        end
        #2 bus.ext_oe_n = 1'b1;
        #1 chk("rd_oe_release", 32'(bus.ext_dq_oe), 0);
        @(negedge clk);
        bus.ext_ce_n = 1'b1;
        wait_idle("rd_idle");
    endtask

    initial begin
        req_t e;
        for (int i = 0; i < (1 << AW); i++) begin
            ref_mem[i]  = 16'(i * 7 + 16'h1234);
            resp_mem[i] = ref_mem[i];
        end
        ref_mem[15'h0040]  = 16'hA55A;
        resp_mem[15'h0040] = 16'hA55A;
        pins_idle();
        bus.ext_addr = '0;
        bus.ext_dq_i = '0;

        repeat (3) @(negedge clk);
        chk("rst_mem_r", 32'(bus.mem_r), 0);
        chk("rst_mem_w", 32'(bus.mem_w), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
        chk("rst_dq_o", 32'(bus.ext_dq_o), 0);
        chk("rst_dq_oe", 32'(bus.ext_dq_oe), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        nreset = 1'b1;
        repeat (2) @(negedge clk);

        // Directed accesses with a zero-wait responder, then wait states on reads.
        fixed_wait = 0;
        do_write(15'h0123, 16'hBEEF, 1'b0, 1'b0, 6, 1'b1);
        chk("wr_err_clear", 32'(err), 0);
        do_write(15'h7FFF, 16'h12AA, 1'b0, 1'b1, 4, 1'b1);
        do_write(15'h0010, 16'hDEAD, 1'b1, 1'b1, 3, 1'b1);
        fixed_wait = 3;
        do_read(15'h0040, 1'b1, 15'h0041, 1'b1);
        fixed_wait = 0;
        do_read(15'h7FFF, 1'b0, 15'h0, 1'b0);
        do_read(15'h0123, 1'b0, 15'h0, 1'b0);

        fixed_wait = -1;
        for (int it = 0; it < 40; it++) begin
            logic [AW-1:0] a, a2;
            a  = AW'($urandom_range(0, 7));
            a2 = AW'((int'(a) + 1 + int'($urandom_range(0, 6))) % 8);
            if ($urandom_range(0, 2) != 0)
                do_write(a, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         int'($urandom_range(1, 4)), 1'b0);
            else
                do_read(a, 1'($urandom_range(0, 1)), a2, 1'b0);
        end
        repeat (4) @(negedge clk);
        chk("req_queue_drained", 32'(exp_q.size()), 0);
        chk("rd_queue_drained", 32'(rd_exp_q.size()), 0);
        chk("rand_err_clear", 32'(err), 0);

        // Overlapping access while a write request is stalled, then reset mid-request.
        fixed_wait = 0;
        hold_ready = 1'b1;
        @(negedge clk);
        bus.ext_addr = 15'h0200;
        bus.ext_dq_i = 16'h1111;
        bus.ext_ub_n = 1'b0;
        bus.ext_lb_n = 1'b0;
        bus.ext_ce_n = 1'b0;
        bus.ext_we_n = 1'b0;
        repeat (3) @(negedge clk);
        pins_idle();
        e.is_wr = 1'b1; e.addr = 15'h0200; e.lanes = LANE_BOTH; e.data = 16'h1111;
        exp_q.push_back(e);
        repeat (SS + 3) @(negedge clk);
        chk("ovl_mem_w_held", 32'(bus.mem_w), 32'(LANE_BOTH));
        chk("ovl_err_before", 32'(err), 0);
        bus.ext_ce_n = 1'b0;
        bus.ext_we_n = 1'b0;
        repeat (2) @(negedge clk);
        pins_idle();
        repeat (SS + 2) @(negedge clk);
        chk("ovl_err_set", 32'(err), 1);
        repeat (5) @(negedge clk);
        chk("ovl_err_sticky", 32'(err), 1);
        chk("ovl_still_busy", 32'(busy), 1);
        chk("ovl_mem_w_still", 32'(bus.mem_w), 32'(LANE_BOTH));
        #3 nreset = 1'b0;
        #1;
        chk("rst_mid_mem_w", 32'(bus.mem_w), 0);
        chk("rst_mid_mem_r", 32'(bus.mem_r), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_err", 32'(err), 0);
        chk("rst_mid_dq_oe", 32'(bus.ext_dq_oe), 0);
        exp_q.delete();
        hold_ready = 1'b0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        repeat (SS + 4) @(negedge clk);
        chk("post_rst_no_req", 32'(bus.mem_r || bus.mem_w != 2'b00), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
